slot_reels: RTL and testbench

//  Producer side of the slot-machine game: generates the three reel numbers consumed by the slots
//  win-check FSM. Three counters spin on a slow tick and freeze one at a time on player key presses
//  (key_1 -> reel1, key_2 -> reel2, key_3 -> reel3). key_3 also starts a new spin once all reels stop.

---
 rtl/slot_reels.sv | 110 +++++++++++
 tb/tb_slot_reels.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/slot_reels.sv
// Reel generator for the slot machine: three counters spin on the divider tick
// and freeze one at a time on debounced-by-edge key presses.
module slot_reels #(
   parameter int REEL_MAX = 9,
   parameter int STEP1    = 1,
   parameter int STEP2    = 3,
   parameter int STEP3    = 7
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       tick,
   input  logic       key_1,
   input  logic       key_2,
   input  logic       key_3,
   output logic [4:0] reel1,
   output logic [4:0] reel2,
   output logic [4:0] reel3,
   output logic [2:0] stopped,
   output logic       spinning,
   output logic       spin_done
);

   // state | meaning
   // DONE  | all reels frozen, waiting for key_3 to start a spin
   // SPIN3 | all three reels spinning
   // SPIN2 | reel1 frozen, reels 2 and 3 spinning
   // SPIN1 | reels 1 and 2 frozen, reel3 spinning
   typedef enum logic [1:0] {DONE, SPIN3, SPIN2, SPIN1} state_t;

   localparam logic [5:0] MAX6  = 6'(REEL_MAX);
   localparam logic [5:0] MOD6  = 6'(REEL_MAX + 1);
   localparam logic [5:0] STEP1_6 = 6'(STEP1);
   localparam logic [5:0] STEP2_6 = 6'(STEP2);
   localparam logic [5:0] STEP3_6 = 6'(STEP3);

   state_t     state, state_nxt;
   logic [2:0] sync_a, sync_b, prev, press;
   logic [2:0] frz, adv;

   function automatic logic [2:0] stop_of(state_t s);
      case (s)
         SPIN3:   return 3'b000;
         SPIN2:   return 3'b001;
         SPIN1:   return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic [4:0] step_reel(logic [4:0] r, logic [5:0] inc);
      logic [5:0] sum;
      sum = {1'b0, r} + inc;
      if (sum > MAX6)
         sum = sum - MOD6;
      return sum[4:0];
   endfunction

   // Press pulse is registered so it lands one cycle after the edge detect.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_a <= 3'b111;
         sync_b <= 3'b111;
         prev   <= 3'b111;
         press  <= 3'b000;
      end else begin
         sync_a <= {key_3, key_2, key_1};
         sync_b <= sync_a;
         prev   <= sync_b;
         press  <= ~sync_b & prev;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DONE:    if (press[2]) state_nxt = SPIN3;
         SPIN3:   if (press[0]) state_nxt = SPIN2;
         SPIN2:   if (press[1]) state_nxt = SPIN1;
         SPIN1:   if (press[2]) state_nxt = DONE;
         default: state_nxt = DONE;
      endcase
   end

   // A reel advances only if it spins both before and after this edge, so a
   // stopping press beats a coincident tick and a restart edge never advances.
   always_comb begin
      frz = stop_of(state) | stop_of(state_nxt);
      adv = {3{tick}} & ~frz;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= DONE;
         reel1     <= 5'd0;
         reel2     <= 5'd0;
         reel3     <= 5'd0;
         stopped   <= 3'b111;
         spinning  <= 1'b0;
         spin_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         stopped   <= stop_of(state_nxt);
         spinning  <= (state_nxt != DONE);
         spin_done <= (state == SPIN1) && (state_nxt == DONE);
         if (adv[0]) reel1 <= step_reel(reel1, STEP1_6);
         if (adv[1]) reel2 <= step_reel(reel2, STEP2_6);
         if (adv[2]) reel3 <= step_reel(reel3, STEP3_6);
      end
   end

endmodule

// File: tb/tb_slot_reels.sv
// Bench for slot_reels: vector table of key/tick operations with hand-derived
// reel values, plus hand-written sequences for held keys and mid-spin reset.
module tb_slot_reels;

   logic       clk = 1'b0;
   logic       resetn;
   logic       tick;
   logic [2:0] kb;
   logic [4:0] reel1, reel2, reel3;
   logic [2:0] stopped;
   logic       spinning, spin_done;

   int passed = 0;
   int total  = 0;
   int sd_count = 0;
   int sd_long  = 0;
   logic sd_prev = 1'b0;

   localparam int OP_PRESS = 0;
   localparam int OP_TICK  = 1;

   typedef struct {
      int         op;
      int         arg;
      logic [4:0] r1, r2, r3;
      logic [2:0] stp;
      logic       spn;
      int         sd;
   } vec_t;

   vec_t vecs[15];
   vec_t sb[$];
   vec_t ex;

   slot_reels dut (
      .clk       (clk),
      .resetn    (resetn),
      .tick      (tick),
      .key_1     (kb[0]),
      .key_2     (kb[1]),
      .key_3     (kb[2]),
      .reel1     (reel1),
      .reel2     (reel2),
      .reel3     (reel3),
      .stopped   (stopped),
      .spinning  (spinning),
      .spin_done (spin_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (spin_done) begin
         sd_count++;
         if (sd_prev) sd_long++;
      end
      sd_prev = spin_done;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
   endtask

   task automatic do_press(input int k);
      @(negedge clk);
      kb[k] = 1'b0;
      repeat (6) @(negedge clk);
      kb[k] = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      //          op        arg r1 r2 r3 stopped  spn sd
      vecs[0]  = '{OP_PRESS, 2, 0, 0, 0, 3'b000, 1, 0};
      vecs[1]  = '{OP_TICK,  4, 4, 2, 8, 3'b000, 1, 0};
      vecs[2]  = '{OP_PRESS, 0, 4, 2, 8, 3'b001, 1, 0};
      vecs[3]  = '{OP_TICK,  3, 4, 1, 9, 3'b001, 1, 0};
      vecs[4]  = '{OP_PRESS, 2, 4, 1, 9, 3'b001, 1, 0};
      vecs[5]  = '{OP_PRESS, 0, 4, 1, 9, 3'b001, 1, 0};
      vecs[6]  = '{OP_TICK,  1, 4, 4, 6, 3'b001, 1, 0};
      vecs[7]  = '{OP_PRESS, 1, 4, 4, 6, 3'b011, 1, 0};
      vecs[8]  = '{OP_TICK,  2, 4, 4, 0, 3'b011, 1, 0};
      vecs[9]  = '{OP_PRESS, 2, 4, 4, 0, 3'b111, 0, 1};
      vecs[10] = '{OP_TICK,  2, 4, 4, 0, 3'b111, 0, 1};
      vecs[11] = '{OP_PRESS, 0, 4, 4, 0, 3'b111, 0, 1};
      vecs[12] = '{OP_PRESS, 1, 4, 4, 0, 3'b111, 0, 1};
      vecs[13] = '{OP_PRESS, 2, 4, 4, 0, 3'b000, 1, 1};
      vecs[14] = '{OP_TICK,  1, 5, 7, 7, 3'b000, 1, 1};

      resetn = 1'b0;
      tick   = 1'b0;
      kb     = 3'b111;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("reset_reel1", reel1, 0);
      chk("reset_reel2", reel2, 0);
      chk("reset_reel3", reel3, 0);
      chk("reset_stopped", stopped, 3'b111);
      chk("reset_spinning", spinning, 0);
      chk("reset_spin_done", sd_count, 0);

      for (int i = 0; i < 15; i++) begin
         sb.push_back(vecs[i]);
         if (vecs[i].op == OP_PRESS) do_press(vecs[i].arg);
         else do_ticks(vecs[i].arg);
         ex = sb.pop_front();
         chk($sformatf("v%0d_reel1", i), reel1, ex.r1);
         chk($sformatf("v%0d_reel2", i), reel2, ex.r2);
         chk($sformatf("v%0d_reel3", i), reel3, ex.r3);
         chk($sformatf("v%0d_stopped", i), stopped, ex.stp);
         chk($sformatf("v%0d_spinning", i), spinning, ex.spn);
         chk($sformatf("v%0d_spin_done_cnt", i), sd_count, ex.sd);
      end

      // Held key_1 with a tick every cycle; reels start at 5/7/7 in SPIN3.
      @(negedge clk);
      kb[0] = 1'b0;
      tick  = 1'b1;
      repeat (3) @(negedge clk);
      chk("hold_before_stop", stopped, 3'b000);
      @(negedge clk);
      chk("hold_stop_edge", stopped, 3'b001);
      chk("hold_press_beats_tick", reel1, 8);
      repeat (45) @(negedge clk);
      tick  = 1'b0;
      kb[0] = 1'b1;
      repeat (4) @(negedge clk);
      chk("hold_reel1", reel1, 8);
      chk("hold_reel2", reel2, 4);
      chk("hold_reel3", reel3, 0);
      chk("hold_single_stop", stopped, 3'b001);
      chk("hold_spinning", spinning, 1);

      // Mid-spin reset in SPIN2.
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("mid_reset_reel1", reel1, 0);
      chk("mid_reset_reel2", reel2, 0);
      chk("mid_reset_reel3", reel3, 0);
      chk("mid_reset_stopped", stopped, 3'b111);
      chk("mid_reset_spinning", spinning, 0);
      do_press(0);
      chk("post_reset_key1_stopped", stopped, 3'b111);
      chk("post_reset_key1_spinning", spinning, 0);
      chk("post_reset_reel1", reel1, 0);
      chk("spin_done_total", sd_count, 1);
      chk("spin_done_width", sd_long, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
